// File: rtl/encoder_4to2.sv
// Purpose : registered 4-to-2 priority encoder with valid flag (optional multi-hot flag).
// Latency : 1 cycle, inputs sampled on rising clk when en=1; en=0 holds outputs.
// Backpressure: none; en acts as a sample/hold qualifier only.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset, clears all outputs immediately
//   en            sample enable
//   i0..i3        request lines, index 0..3
//   y1,y0         encoded index of the winning request
//   valid         at least one request was high at the last sample
//   multi         (ENCODER_MULTI_ERR_EN only) two or more requests were high
//
// Parameter HIGH_PRIO: 1 -> i3 wins ties, 0 -> i0 wins ties.
// Optional feature macro: ENCODER_MULTI_ERR_EN adds the multi output.

module encoder_4to2 #(
  parameter int HIGH_PRIO = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic y0,
  output logic y1,
  output logic valid
`ifdef ENCODER_MULTI_ERR_EN
  ,
  output logic multi
`endif
);

  logic [3:0] req;
  logic [1:0] idx_nxt;
  logic       valid_nxt;

  assign req = {i3, i2, i1, i0};

  // Priority selection; an all-zero request falls through to index 0.
  always_comb begin
    idx_nxt = 2'b00;
    if (HIGH_PRIO != 0) begin
      if (req[3])      idx_nxt = 2'b11;
      else if (req[2]) idx_nxt = 2'b10;
      else if (req[1]) idx_nxt = 2'b01;
      else             idx_nxt = 2'b00;
    end else begin
      if (req[0])      idx_nxt = 2'b00;
      else if (req[1]) idx_nxt = 2'b01;
      else if (req[2]) idx_nxt = 2'b10;
      else if (req[3]) idx_nxt = 2'b11;
      else             idx_nxt = 2'b00;
    end
  end

  assign valid_nxt = |req;

`ifdef ENCODER_MULTI_ERR_EN
  logic multi_nxt;

  // Any pair of simultaneously active requests means two or more are high.
  assign multi_nxt = (req[0] & req[1]) | (req[0] & req[2]) | (req[0] & req[3]) |
                     (req[1] & req[2]) | (req[1] & req[3]) | (req[2] & req[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi <= 1'b0;
    end else if (en) begin
      multi <= multi_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1    <= 1'b0;
      y0    <= 1'b0;
      valid <= 1'b0;
    end else if (en) begin
      y1    <= idx_nxt[1];
      y0    <= idx_nxt[0];
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_4to2.sv
// Purpose : directed self-checking bench for encoder_4to2, both priority orders side by side.
// Latency : expects outputs one rising edge after inputs are applied.
// Backpressure: n/a; en exercised as a hold control.

module tb_encoder_4to2;

  logic clk;
  logic rst_n;
  logic en;
  logic [3:0] req;  // {i3,i2,i1,i0}

  logic hi_y0, hi_y1, hi_valid;
  logic lo_y0, lo_y1, lo_valid;
`ifdef ENCODER_MULTI_ERR_EN
  logic hi_multi, lo_multi;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  encoder_4to2 #(.HIGH_PRIO(1)) u_dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i0    (req[0]),
    .i1    (req[1]),
    .i2    (req[2]),
    .i3    (req[3]),
    .y0    (hi_y0),
    .y1    (hi_y1),
    .valid (hi_valid)
`ifdef ENCODER_MULTI_ERR_EN
    ,
    .multi (hi_multi)
`endif
  );

  encoder_4to2 #(.HIGH_PRIO(0)) u_dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i0    (req[0]),
    .i1    (req[1]),
    .i2    (req[2]),
    .i3    (req[3]),
    .y0    (lo_y0),
    .y1    (lo_y1),
    .valid (lo_valid)
`ifdef ENCODER_MULTI_ERR_EN
    ,
    .multi (lo_multi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {y1,y0,valid} of each instance.
  function automatic logic [3:0] hi_out();
    return {1'b0, hi_y1, hi_y0, hi_valid};
  endfunction

  function automatic logic [3:0] lo_out();
    return {1'b0, lo_y1, lo_y0, lo_valid};
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1000;

    // Reset held with i3 active and clocks running.
    tick();
    tick();
    chk("rst_hold_hi", hi_out(), 4'b0000);
    chk("rst_hold_lo", lo_out(), 4'b0000);
`ifdef ENCODER_MULTI_ERR_EN
    chk("rst_hold_multi", {3'b000, hi_multi}, 4'b0000);
`endif

    // Release between edges; first sample on the next edge.
    rst_n = 1'b1;
    chk("rst_rel_pre_edge", hi_out(), 4'b0000);
    tick();
    chk("rst_rel_hi", hi_out(), 4'b0111);
    chk("rst_rel_lo", lo_out(), 4'b0111);

    // One-hot sweep: index k -> {y1,y0}=k, valid=1 in both orders.
    for (int k = 0; k < 4; k++) begin
      req = 4'b0001 << k;
      tick();
      chk($sformatf("onehot%0d_hi", k), hi_out(), {1'b0, k[1:0], 1'b1});
      chk($sformatf("onehot%0d_lo", k), lo_out(), {1'b0, k[1:0], 1'b1});
`ifdef ENCODER_MULTI_ERR_EN
      chk($sformatf("onehot%0d_multi", k), {3'b000, hi_multi}, 4'b0000);
`endif
    end

    // Idle.
    req = 4'b0000;
    tick();
    chk("idle_hi", hi_out(), 4'b0000);
    chk("idle_lo", lo_out(), 4'b0000);
`ifdef ENCODER_MULTI_ERR_EN
    chk("idle_multi", {3'b000, lo_multi}, 4'b0000);
`endif

    // i1 and i2 together: high-prio order picks 2, low-prio picks 1.
    req = 4'b0110;
    tick();
    chk("prio_i1i2_hi", hi_out(), 4'b0101);
    chk("prio_i1i2_lo", lo_out(), 4'b0011);
`ifdef ENCODER_MULTI_ERR_EN
    chk("prio_i1i2_multi_hi", {3'b000, hi_multi}, 4'b0001);
    chk("prio_i1i2_multi_lo", {3'b000, lo_multi}, 4'b0001);
`endif

    // Extreme corners: i0 and i3 together, then all four.
    req = 4'b1001;
    tick();
    chk("prio_i0i3_hi", hi_out(), 4'b0111);
    chk("prio_i0i3_lo", lo_out(), 4'b0001);

    req = 4'b1111;
    tick();
    chk("prio_all_hi", hi_out(), 4'b0111);
    chk("prio_all_lo", lo_out(), 4'b0001);

    // Hold: load i2, then en=0 and switch to i0.
    req = 4'b0100;
    tick();
    chk("hold_load", hi_out(), 4'b0101);
    en  = 1'b0;
    req = 4'b0001;
    tick();
    chk("hold_1_hi", hi_out(), 4'b0101);
    chk("hold_1_lo", lo_out(), 4'b0101);
`ifdef ENCODER_MULTI_ERR_EN
    chk("hold_multi", {3'b000, hi_multi}, 4'b0000);
`endif
    req = 4'b0000;
    tick();
    chk("hold_2_idle_in", hi_out(), 4'b0101);
    req = 4'b0001;
    en  = 1'b1;
    tick();
    chk("hold_release_hi", hi_out(), 4'b0001);
    chk("hold_release_lo", lo_out(), 4'b0001);

    // Asynchronous reset mid-cycle while outputs are 11.
    req = 4'b1000;
    tick();
    chk("arst_pre", hi_out(), 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_async_hi", hi_out(), 4'b0000);
    chk("arst_async_lo", lo_out(), 4'b0000);
    // Reset overrides en and inputs across an edge.
    tick();
    chk("arst_held_edge", hi_out(), 4'b0000);
    #2;
    rst_n = 1'b1;
    tick();
    chk("arst_recover", hi_out(), 4'b0111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
